// File: rtl/round_key_arbiter.sv
// rtl/round_key_arbiter.sv - shares the key-expansion round-key port between encrypt and decrypt engines
// Sequences key expansion after reset/re-key, then serves one round-robin round-key lookup at a time.
module round_key_arbiter #(
  parameter int KW         = 128,
  parameter int KE_CYCLES  = 10,
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_LAT    = 1
) (
  input  logic          clk,
  input  logic          trst,
  input  logic          key_load,
  output logic          ke_en,
  output logic [3:0]    ke_round,
  input  logic [KW-1:0] ke_key,
  output logic          key_ready,
  input  logic          enc_req,
  input  logic [3:0]    enc_round,
  output logic          enc_ack,
  output logic [KW-1:0] enc_key,
  input  logic          dec_req,
  input  logic [3:0]    dec_round,
  output logic          dec_ack,
  output logic [KW-1:0] dec_key,
  output logic          round_err,
  output logic          busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int CMAX = (KE_CYCLES > KEY_LAT) ? KE_CYCLES : KEY_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] KE_END   = CW'(KE_CYCLES);
  localparam logic [CW-1:0] LAT_LOAD = CW'(KEY_LAT);
  localparam logic [3:0]    MAX_RND  = 4'(NUM_ROUNDS);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_dec_q, last_dec_d;
  logic            sel_dec_q, sel_dec_d;
  logic            ke_en_q, ke_en_d;
  logic [3:0]      ke_round_q, ke_round_d;
  logic            key_ready_q, key_ready_d;
  logic            enc_ack_q, enc_ack_d;
  logic            dec_ack_q, dec_ack_d;
  logic [KW-1:0]   enc_key_q, enc_key_d;
  logic [KW-1:0]   dec_key_q, dec_key_d;
  logic            round_err_q, round_err_d;
  logic            busy_q, busy_d;

  logic            gnt_dec;
  logic [3:0]      req_round;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dec_d  = last_dec_q;
    sel_dec_d   = sel_dec_q;
    ke_en_d     = ke_en_q;
    ke_round_d  = ke_round_q;
    key_ready_d = key_ready_q;
    enc_ack_d   = 1'b0;
    dec_ack_d   = 1'b0;
    enc_key_d   = enc_key_q;
    dec_key_d   = dec_key_q;
    round_err_d = 1'b0;

    // On a tie the grant goes to whoever did not win the previous tie.
    gnt_dec   = dec_req & (~enc_req | ~last_dec_q);
    req_round = gnt_dec ? dec_round : enc_round;

    case (state_q)
      S_INIT: begin
        if (cnt_q == KE_END) begin
          ke_en_d     = 1'b0;
          key_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          ke_en_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (enc_req | dec_req) begin
          sel_dec_d = gnt_dec;
          if (enc_req & dec_req) last_dec_d = gnt_dec;
          if (req_round > MAX_RND) begin
            if (gnt_dec) dec_key_d = '0;
            else         enc_key_d = '0;
            enc_ack_d   = ~gnt_dec;
            dec_ack_d   = gnt_dec;
            round_err_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            ke_round_d = req_round;
            cnt_d      = LAT_LOAD;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (sel_dec_q) dec_key_d = ke_key;
          else           enc_key_d = ke_key;
          enc_ack_d = ~sel_dec_q;
          dec_ack_d = sel_dec_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Re-key wins over any grant or capture decided above.
    if (key_load) begin
      state_d     = S_INIT;
      cnt_d       = '0;
      key_ready_d = 1'b0;
      ke_en_d     = 1'b0;
      enc_ack_d   = 1'b0;
      dec_ack_d   = 1'b0;
      round_err_d = 1'b0;
      enc_key_d   = enc_key_q;
      dec_key_d   = dec_key_q;
      ke_round_d  = ke_round_q;
      last_dec_d  = last_dec_q;
      sel_dec_d   = sel_dec_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge trst) begin
    if (!trst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      last_dec_q  <= 1'b1;
      sel_dec_q   <= 1'b0;
      ke_en_q     <= 1'b0;
      ke_round_q  <= '0;
      key_ready_q <= 1'b0;
      enc_ack_q   <= 1'b0;
      dec_ack_q   <= 1'b0;
      enc_key_q   <= '0;
      dec_key_q   <= '0;
      round_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dec_q  <= last_dec_d;
      sel_dec_q   <= sel_dec_d;
      ke_en_q     <= ke_en_d;
      ke_round_q  <= ke_round_d;
      key_ready_q <= key_ready_d;
      enc_ack_q   <= enc_ack_d;
      dec_ack_q   <= dec_ack_d;
      enc_key_q   <= enc_key_d;
      dec_key_q   <= dec_key_d;
      round_err_q <= round_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ke_en     = ke_en_q;
  assign ke_round  = ke_round_q;
  assign key_ready = key_ready_q;
  assign enc_ack   = enc_ack_q;
  assign dec_ack   = dec_ack_q;
  assign enc_key   = enc_key_q;
  assign dec_key   = dec_key_q;
  assign round_err = round_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_round_key_arbiter.sv
// tb/tb_round_key_arbiter.sv - directed scoreboard bench for round_key_arbiter
module tb_round_key_arbiter;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          trst = 1'b0;
  logic          key_load = 1'b0;
  logic          ke_en;
  logic [3:0]    ke_round;
  logic [KW-1:0] ke_key = '0;
  logic          key_ready;
  logic          enc_req = 1'b0;
  logic [3:0]    enc_round = '0;
  logic          enc_ack;
  logic [KW-1:0] enc_key;
  logic          dec_req = 1'b0;
  logic [3:0]    dec_round = '0;
  logic          dec_ack;
  logic [KW-1:0] dec_key;
  logic          round_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_dec;
    logic [KW-1:0] key;
    logic          err;
  } exp_t;
  exp_t sb[$];

  round_key_arbiter #(.KW(KW), .KE_CYCLES(10), .NUM_ROUNDS(10), .KEY_LAT(1)) dut (
    .clk(clk), .trst(trst), .key_load(key_load),
    .ke_en(ke_en), .ke_round(ke_round), .ke_key(ke_key), .key_ready(key_ready),
    .enc_req(enc_req), .enc_round(enc_round), .enc_ack(enc_ack), .enc_key(enc_key),
    .dec_req(dec_req), .dec_round(dec_round), .dec_ack(dec_ack), .dec_key(dec_key),
    .round_err(round_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [KW-1:0] kfn(input logic [3:0] r);
    return {16{r, 4'hA}};
  endfunction

  // Key-expansion model with one edge of latency.
  always @(posedge clk) ke_key <= kfn(ke_round);

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input int budget, output int lat);
    exp_t e;
    logic got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      got = enc_ack | dec_ack;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_ack expected=ack within %0d cycles", tag, budget);
    end
    if (got) begin
      check({tag, "_sb_pending"}, KW'(sb.size() > 0), KW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_which"}, KW'(dec_ack), KW'(e.is_dec));
        check({tag, "_both_ack"}, KW'(enc_ack & dec_ack), KW'(0));
        check({tag, "_key"}, e.is_dec ? dec_key : enc_key, e.key);
        check({tag, "_err"}, KW'(round_err), KW'(e.err));
      end
    end
  endtask

  initial begin
    int lat;
    int hi;
    int early;
    int n;

    tick(2);
    check("rst_ke_en", KW'(ke_en), KW'(0));
    check("rst_key_ready", KW'(key_ready), KW'(0));
    check("rst_busy", KW'(busy), KW'(0));
    check("rst_ke_round", KW'(ke_round), KW'(0));
    check("rst_enc_key", enc_key, KW'(0));
    check("rst_dec_key", dec_key, KW'(0));

    // 1: expansion after reset, request held through INIT
    enc_req = 1'b1; enc_round = 4'd3;
    sb.push_back('{1'b0, kfn(4'd3), 1'b0});
    trst = 1'b1;
    hi = 0; early = 0;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      hi += int'(ke_en);
      if (enc_ack | dec_ack) early++;
      if (e == 0) check("t1_ke_en_edge0", KW'(ke_en), KW'(1));
      if (e == 9) begin
        check("t1_ke_en_edge9", KW'(ke_en), KW'(1));
        check("t1_ready_edge9", KW'(key_ready), KW'(0));
      end
      if (e == 10) begin
        check("t1_ke_en_edge10", KW'(ke_en), KW'(0));
        check("t1_ready_edge10", KW'(key_ready), KW'(1));
      end
    end
    check("t1_ke_en_cycles", KW'(hi), KW'(10));
    check("t1_no_early_ack", KW'(early), KW'(0));
    wait_ack("t1", 10, lat);
    check("t1_latency", KW'(lat), KW'(3));
    enc_req = 1'b0;

    // 2: single encrypt lookup, round 3
    tick(2);
    enc_req = 1'b1; enc_round = 4'd3;
    sb.push_back('{1'b0, kfn(4'd3), 1'b0});
    wait_ack("t2", 10, lat);
    check("t2_latency", KW'(lat), KW'(3));
    enc_req = 1'b0;
    tick(1);
    check("t2_ack_one_cycle", KW'(enc_ack), KW'(0));

    // 3: both held, grants alternate enc, dec, enc
    tick(1);
    enc_req = 1'b1; enc_round = 4'd0;
    dec_req = 1'b1; dec_round = 4'd10;
    sb.push_back('{1'b0, kfn(4'd0), 1'b0});
    sb.push_back('{1'b1, kfn(4'd10), 1'b0});
    sb.push_back('{1'b0, kfn(4'd0), 1'b0});
    wait_ack("t3a", 10, lat);
    wait_ack("t3b", 10, lat);
    wait_ack("t3c", 10, lat);
    enc_req = 1'b0; dec_req = 1'b0;

    // 4: out-of-range decrypt round
    tick(1);
    dec_req = 1'b1; dec_round = 4'd12;
    sb.push_back('{1'b1, KW'(0), 1'b1});
    wait_ack("t4", 10, lat);
    check("t4_latency", KW'(lat), KW'(1));
    check("t4_ke_round_kept", KW'(ke_round), KW'(0));
    check("t4_enc_key_kept", enc_key, kfn(4'd0));
    dec_req = 1'b0;
    tick(1);
    check("t4_err_one_cycle", KW'(round_err), KW'(0));
    check("t4_ack_one_cycle", KW'(dec_ack), KW'(0));

    // 5: key_load during WAIT drops the lookup, then re-expands and serves it
    enc_req = 1'b1; enc_round = 4'd5;
    sb.push_back('{1'b0, kfn(4'd5), 1'b0});
    tick(1);
    check("t5_busy_wait", KW'(busy), KW'(1));
    key_load = 1'b1;
    tick(1);
    key_load = 1'b0;
    check("t5_ready_cleared", KW'(key_ready), KW'(0));
    check("t5_no_ack", KW'(enc_ack), KW'(0));
    check("t5_enc_key_kept", enc_key, kfn(4'd0));
    check("t5_dec_key_kept", dec_key, KW'(0));
    hi = 0; early = 0; n = 0;
    while (!key_ready && n < 30) begin
      @(negedge clk);
      n++;
      hi += int'(ke_en);
      if (enc_ack | dec_ack) early++;
    end
    check("t5_reexpand_edges", KW'(n), KW'(11));
    check("t5_ke_en_cycles", KW'(hi), KW'(10));
    check("t5_no_ack_in_init", KW'(early), KW'(0));
    wait_ack("t5", 10, lat);
    check("t5_latency", KW'(lat), KW'(3));
    enc_req = 1'b0;

    // 6: asynchronous reset while in RESP
    tick(1);
    enc_req = 1'b1; enc_round = 4'd7;
    sb.push_back('{1'b0, kfn(4'd7), 1'b0});
    wait_ack("t6", 10, lat);
    enc_req = 1'b0;
    #2 trst = 1'b0;
    #1;
    check("t6_enc_ack", KW'(enc_ack), KW'(0));
    check("t6_key_ready", KW'(key_ready), KW'(0));
    check("t6_busy", KW'(busy), KW'(0));
    check("t6_enc_key", enc_key, KW'(0));
    check("t6_dec_key", dec_key, KW'(0));
    check("sb_drained", KW'(sb.size()), KW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
